// File: rtl/cnn_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cnn_pkg
// Brief    : Shared types and defaults for the CNN pixel-feed datapath.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package cnn_pkg;

   localparam int PIXEL_W   = 8;
   localparam int IMG_W_DEF = 28;
   localparam int IMG_H_DEF = 28;
   localparam int K_DEF     = 5;

   // Frame scheduler states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_feed_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : conv_feed_scheduler_if
// Brief    : Start, FIFO-read and conv-output signal bundle of the scheduler.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface conv_feed_scheduler_if
   import cnn_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
);

   logic                       i_start;
   logic                       o_rd_en;
   logic                       i_feature_valid;
   logic [PIXEL_W-1:0]         i_feature;
   logic                       i_conv_ready;
   logic                       o_pixel_valid;
   logic [PIXEL_W-1:0]         o_pixel;
   logic [$clog2(IMG_H)-1:0]   o_row;
   logic [$clog2(IMG_W)-1:0]   o_col;
   logic                       o_window_valid;
   logic                       o_busy;
   logic                       o_frame_done;

   // Scheduler side
   modport master (
      input  i_start, i_feature_valid, i_feature, i_conv_ready,
      output o_rd_en, o_pixel_valid, o_pixel, o_row, o_col,
             o_window_valid, o_busy, o_frame_done
   );

   // Environment side (FIFO, conv block, controller)
   modport slave (
      output i_start, i_feature_valid, i_feature, i_conv_ready,
      input  o_rd_en, o_pixel_valid, o_pixel, o_row, o_col,
             o_window_valid, o_busy, o_frame_done
   );

endinterface
`default_nettype wire

// File: rtl/skid_buffer2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : skid_buffer2
// Brief    : Two-entry FIFO-style skid buffer; head entry drives the output.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module skid_buffer2 #(
   parameter int DATA_W = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              push,
   input  wire logic [DATA_W-1:0] push_data,
   input  wire logic              pop,
   output logic                   head_valid,
   output logic [DATA_W-1:0]      head_data,
   output logic [1:0]             occupancy
);

   logic [DATA_W-1:0] r_entry0;
   logic [DATA_W-1:0] r_entry1;
   logic [1:0]        r_count;
   logic              w_pop;

   // A pop request against an empty buffer is a no-op
   assign w_pop = pop && (r_count != 2'd0);

   // Entry 0 is always the head; entry 1 shifts forward on pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entry0 <= '0;
         r_entry1 <= '0;
         r_count  <= 2'd0;
      end else begin
         case ({push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_entry0 <= push_data;
               else                 r_entry1 <= push_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_entry0 <= r_entry1;
               r_count  <= r_count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: pop head, push tail
               if (r_count == 2'd1) begin
                  r_entry0 <= push_data;
               end else begin
                  r_entry0 <= r_entry1;
                  r_entry1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_valid = (r_count != 2'd0);
   assign head_data  = r_entry0;
   assign occupancy  = r_count;

endmodule
`default_nettype wire

// File: rtl/conv_feed_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : conv_feed_scheduler
// Brief    : Reads one image frame from a pixel FIFO and streams it, with
//            row/column tags and KxK window flags, to a convolution block.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module conv_feed_scheduler
   import cnn_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int K     = K_DEF
) (
   input  wire logic              i_sys_clk,
   input  wire logic              i_rst,
   conv_feed_scheduler_if.master  bus
);

   localparam int RW   = $clog2(IMG_H);
   localparam int CW   = $clog2(IMG_W);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int QW   = $clog2(NPIX + 1);

   localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
   localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
   localparam logic [RW-1:0] c_row_k    = RW'(K - 1);
   localparam logic [CW-1:0] c_col_k    = CW'(K - 1);
   localparam logic [QW-1:0] c_npix     = QW'(NPIX);

   state_t              r_state;
   logic                r_busy;
   logic                r_frame_done;
   logic [QW-1:0]       r_req_cnt;
   logic                r_in_flight;
   logic [RW-1:0]       r_row;
   logic [CW-1:0]       r_col;

   logic                w_head_valid;
   logic [PIXEL_W-1:0]  w_head_data;
   logic [1:0]          w_occ;
   logic                w_rd_en;
   logic                w_xfer;
   logic                w_last_xfer;

   skid_buffer2 #(
      .DATA_W (PIXEL_W)
   ) u_skid (
      .clk        (i_sys_clk),
      .rst        (i_rst),
      .push       (bus.i_feature_valid),
      .push_data  (bus.i_feature),
      .pop        (bus.i_conv_ready),
      .head_valid (w_head_valid),
      .head_data  (w_head_data),
      .occupancy  (w_occ)
   );

   // Reads in flight count against buffer space so a push never overflows
   assign w_rd_en     = (r_state == ST_STREAM) && (r_req_cnt < c_npix) &&
                        ((w_occ + {1'b0, r_in_flight}) < 2'd2);
   assign w_xfer      = w_head_valid && bus.i_conv_ready;
   assign w_last_xfer = w_xfer && (r_row == c_row_last) && (r_col == c_col_last);

   // Frame FSM with registered status outputs and read bookkeeping
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_req_cnt    <= '0;
         r_in_flight  <= 1'b0;
      end else begin
         r_in_flight <= w_rd_en;
         if (w_rd_en) r_req_cnt <= r_req_cnt + QW'(1);
         case (r_state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  r_state   <= ST_STREAM;
                  r_busy    <= 1'b1;
                  r_req_cnt <= '0;
               end
            end
            ST_STREAM: begin
               if (w_last_xfer) begin
                  r_state      <= ST_DONE;
                  r_frame_done <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   // Raster position of the head pixel; advances only on a transfer
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_xfer) begin
         if (r_col == c_col_last) begin
            r_col <= '0;
            r_row <= (r_row == c_row_last) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   assign bus.o_rd_en        = w_rd_en;
   assign bus.o_pixel_valid  = w_head_valid;
   assign bus.o_pixel        = w_head_data;
   assign bus.o_row          = r_row;
   assign bus.o_col          = r_col;
   assign bus.o_window_valid = w_head_valid && (r_row >= c_row_k) && (r_col >= c_col_k);
   assign bus.o_busy         = r_busy;
   assign bus.o_frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: doc/conv_feed_scheduler.md
CONV_FEED_SCHEDULER -- requirements
Module: conv_feed_scheduler

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Parameter K, default 5, convolution kernel edge length.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 i_sys_clk  input  1  system clock; all logic on rising edge.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_start  input  1  single-cycle pulse; begin one frame.
REQ-008 o_rd_en  output  1  read request to pixel FIFO.
REQ-009 i_feature_valid  input  1  FIFO read data valid; arrives one cycle after o_rd_en.
REQ-010 i_feature  input  8  FIFO read data.
REQ-011 i_conv_ready  input  1  conv block accepts the current pixel this cycle.
REQ-012 o_pixel_valid  output  1  o_pixel, o_row and o_col are valid.
REQ-013 o_pixel  output  8  pixel to conv block.
REQ-014 o_row  output  $clog2(IMG_H)  row index of o_pixel.
REQ-015 o_col  output  $clog2(IMG_W)  column index of o_pixel.
REQ-016 o_window_valid  output  1  o_pixel completes a full KxK window.
REQ-017 o_busy  output  1  high while a frame is in progress.
REQ-018 o_frame_done  output  1  one-cycle pulse after the last pixel transfers.

Function
REQ-019 FSM states: IDLE, STREAM, DONE.
REQ-020 IDLE -> STREAM on i_start; i_start in STREAM or DONE is ignored.
REQ-021 STREAM -> DONE in the cycle after the transfer of pixel (IMG_H-1, IMG_W-1).
REQ-022 DONE -> IDLE unconditionally after one cycle; o_frame_done = 1 only in DONE.
REQ-023 o_busy = 1 in STREAM and DONE.
REQ-024 A transfer occurs when o_pixel_valid && i_conv_ready.
REQ-025 2-entry skid buffer holds FIFO data; o_pixel and o_pixel_valid come from the head entry.
REQ-026 o_rd_en = STREAM && requests_issued < IMG_W*IMG_H && (occupancy + in-flight read) < 2.
REQ-027 Every i_feature_valid pushes i_feature into the skid buffer; an overflow push is not possible by REQ-026.
REQ-028 While i_conv_ready is low, o_pixel_valid, o_pixel, o_row and o_col hold stable.
REQ-029 Column counter wraps IMG_W-1 -> 0 on transfer and increments row; row wraps to 0 at frame end.
REQ-030 o_window_valid = o_pixel_valid && o_row >= K-1 && o_col >= K-1; (IMG_H-K+1)*(IMG_W-K+1) per frame.
REQ-031 Latency: first o_pixel_valid occurs 2 cycles after the first o_rd_en, given i_feature_valid one cycle after o_rd_en.
REQ-032 Simultaneous push and pop on a full buffer: pop head, push tail; occupancy unchanged.
REQ-033 At most IMG_W*IMG_H reads are issued per frame; no o_rd_en outside STREAM.

Reset
REQ-034 While i_rst = 1: state IDLE, counters 0, skid buffer empty, request count 0.
REQ-035 While i_rst = 1, all outputs are 0.
REQ-036 Reset mid-frame abandons the frame and does not pulse o_frame_done; the next i_start begins at (0,0).

Structure
REQ-037 Shared package cnn_pkg holds the FSM state typedef, PIXEL_W = 8, and the IMG_W, IMG_H and K defaults.
REQ-038 The skid buffer is one sub-module, skid_buffer2, parameterised on data width.

Verification
REQ-039 Ready held 1, FIFO preloaded with 0..783 -> 784 transfers, pixel = (row*28 + col) mod 256, 576 window_valid, one frame_done.
REQ-040 Ready toggled at 10 cycles high / 10 cycles low -> no lost or duplicated pixels; outputs stable while ready is low.
REQ-041 i_start pulsed mid-STREAM -> no effect; frame completes with 784 transfers.
REQ-042 i_rst asserted after 300 transfers -> outputs 0 immediately; new i_start restarts at row 0, col 0.
REQ-043 Ready held 0 from the start -> o_rd_en stops after 2 outstanding reads and occupancy stays at 2 or less.
REQ-044 First window_valid occurs at row 4, col 4, which is transfer index 116.
